// File: rtl/fifo_if.sv
// fifo_if: producer/consumer side of the fifo (write request, read request, flags, read data).
// Latency/backpressure: none here; full_flag/empty_flag returned by the fifo gate the requests.
interface fifo_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic             full_flag;
    logic [WIDTH-1:0] rdata;
    logic             rd_en;
    logic             empty_flag;

    modport master (
        output wdata,
        output wr_en,
        output rd_en,
        input  full_flag,
        input  rdata,
        input  empty_flag
    );

    modport slave (
        input  wdata,
        input  wr_en,
        input  rd_en,
        output full_flag,
        output rdata,
        output empty_flag
    );
endinterface

// File: rtl/fifo.sv
// fifo: single-clock DEPTH x WIDTH queue; a write is readable one edge later, rdata is registered on pop.
// Backpressure via full_flag/empty_flag; writes when full and reads when empty are silently dropped.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    fifo_if.slave  bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_rdata;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = bus.wr_en & ~w_full;
    assign w_rd_acc = bus.rd_en & ~w_empty;

    assign bus.full_flag  = w_full;
    assign bus.empty_flag = w_empty;
    assign bus.rdata      = r_rdata;

    // Storage is left uncleared: after reset every entry is behind the pointers.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rdata <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr  <= r_rptr + 1'b1;
                r_rdata <= r_mem[r_rptr];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: scoreboard bench for fifo; a queue model predicts rdata and flags for every cycle.
// Words are pushed when the model accepts a write and popped when it accepts a read.
module tb_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_if #(.WIDTH(WIDTH)) bus ();

    fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [WIDTH-1:0] sb_q [$];
    int               m_count = 0;
    logic [WIDTH-1:0] m_rdata = '0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".empty"}, {31'd0, bus.empty_flag}, {31'd0, m_count == 0});
        chk({tag, ".full"},  {31'd0, bus.full_flag},  {31'd0, m_count == DEPTH});
    endtask

    // One clock: drive at negedge, update model with pre-edge state, compare after the edge.
    task automatic step(input logic wr, input logic [WIDTH-1:0] wd, input logic rd, input string tag);
        bit wacc;
        bit racc;
        @(negedge clk);
        bus.wr_en = wr;
        bus.wdata = wd;
        bus.rd_en = rd;
        wacc = wr && (m_count < DEPTH);
        racc = rd && (m_count > 0);
        if (racc) m_rdata = sb_q.pop_front();
        if (wacc) sb_q.push_back(wd);
        m_count = m_count + (wacc ? 1 : 0) - (racc ? 1 : 0);
        @(posedge clk);
        #1;
        chk({tag, ".rdata"}, bus.rdata, m_rdata);
        chk_flags(tag);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_count = 0;
        m_rdata = '0;
    endtask

    initial begin
        bus.wdata = '0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;

        // Asynchronous reset asserted between edges.
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst0.rdata", bus.rdata, '0);
        chk_flags("rst0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Fill with alternating pattern.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, (i % 2 == 0) ? 32'hD4F40099 : 32'h281B86C4, 1'b0, "fill");
            if (i == 0) chk("fill.first_empty", {31'd0, bus.empty_flag}, '0);
        end
        chk("fill.full", {31'd0, bus.full_flag}, 32'd1);

        step(1'b1, 32'hBABABABA, 1'b0, "ovf");

        // Drain in write order, then one read past empty.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, "drain");
            chk("drain.not_ovf", {31'd0, bus.rdata == 32'hBABABABA}, '0);
        end
        chk("drain.empty", {31'd0, bus.empty_flag}, 32'd1);
        step(1'b0, '0, 1'b1, "underflow");
        chk("underflow.rdata", bus.rdata, 32'h281B86C4);

        // Simultaneous access while empty: only the write lands.
        step(1'b1, 32'h0000A5A5, 1'b1, "both_empty");
        step(1'b0, '0, 1'b1, "both_empty.pop");

        // Wrap with simultaneous traffic at steady occupancy of 2.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h0000_0100 + i, 1'b0, "wrap.wr");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "wrap.rd");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h0000_0200 + i, 1'b1, "wrap.both");
            chk("wrap.noflag", {30'd0, bus.empty_flag, bus.full_flag}, '0);
        end

        // Reset with 3 words stored; nothing pre-reset may come back.
        step(1'b1, 32'h0000_0300, 1'b0, "mid.wr");
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("mid.rdata", bus.rdata, '0);
        chk_flags("mid");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 32'hFEFEFEFE, 1'b0, "post.wr");
        step(1'b0, '0, 1'b1, "post.rd");
        chk("post.rdata", bus.rdata, 32'hFEFEFEFE);
        chk("post.empty", {31'd0, bus.empty_flag}, 32'd1);

        // Simultaneous access while full: only the read lands.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h0000_0400 + i, 1'b0, "refill");
        step(1'b1, 32'hC3C3C3C3, 1'b1, "both_full");
        chk("both_full.rdata", bus.rdata, 32'h0000_0400);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, "final.drain");
        chk("final.last", bus.rdata, 32'h0000_0407);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo.md
# fifo

Synchronous single-clock first-in/first-out buffer that queues WIDTH-bit words between a producer and a consumer in the same clock domain. Writes and reads are qualified by enables and guarded by full and empty flags. Overflow writes and underflow reads are dropped without corrupting stored data. It sits between a data source and a data sink that may stall independently.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 8, number of storage entries; power of two, ≥ 2
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- wdata  input  WIDTH  write data, sampled on rising clk when the write is accepted
- wr_en  input  1  write request
- full_flag  output  1  high when DEPTH words are stored
- rdata  output  WIDTH  registered read data; holds the last word popped
- rd_en  input  1  read request
- empty_flag  output  1  high when no words are stored

## Operation
- Storage: DEPTH×WIDTH register array, write pointer, read pointer (log2(DEPTH) bits each, wrap modulo DEPTH), occupancy count (log2(DEPTH)+1 bits, range 0..DEPTH).
- Write accepted = wr_en & !full_flag at the rising edge: mem[wptr] ← wdata, wptr ← wptr+1.
- Read accepted = rd_en & !empty_flag at the rising edge: rdata ← mem[rptr], rptr ← rptr+1.
- Count: +1 on write only, −1 on read only, unchanged on both or neither.
- full_flag = (count == DEPTH); empty_flag = (count == 0). Both are decoded combinationally from registered count.
- Write while full: ignored. Memory, pointers, count and flags are unchanged.
- Read while empty: ignored. rdata holds its previous value; pointers and count are unchanged.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both accepted, count unchanged.
  - Empty: only the write is accepted.
  - Full: only the read is accepted; the write is dropped that cycle.
- Order is strictly preserved across pointer wrap-around.
- Reset (rst=0, asynchronous, any time including mid-transfer):
  - wptr = rptr = count = 0, rdata = 0.
  - Therefore empty_flag = 1, full_flag = 0.
  - Memory contents need not be cleared; they are unreachable after reset.
- No error outputs. Overflow and underflow are silent.

## Timing
- Flags reflect state after the most recent edge. They are valid throughout the following cycle for the producer and consumer to sample.
- Write-to-read latency: a word written at edge N is readable (empty_flag low) after edge N. The earliest rd_en acceptance is edge N+1.
- Read latency: rdata updates at the accepting edge and is valid from that edge until the next accepted read.
- The cycle after the DEPTH-th accepted write (no reads) has full_flag = 1. The cycle after the last word is popped has empty_flag = 1.
- Reset assertion takes effect immediately, without waiting for clk. Deassertion is honoured on the next rising edge; inputs should be stable around it.

## Test plan
- Reset: assert rst=0 mid-cycle → empty_flag=1, full_flag=0, rdata=0 immediately, with no clk edge required.
- Fill: 8 consecutive writes alternating 32'hD4F40099 / 32'h281B86C4 → empty_flag falls after the first write; full_flag=1 after the 8th write.
- Overflow: with the FIFO full, write 32'hBABABABA → dropped. Count stays 8, and subsequent reads never return 32'hBABABABA.
- Drain: 8 consecutive reads → rdata returns 32'hD4F40099, 32'h281B86C4, … in write order; empty_flag=1 after the 8th read. An extra read leaves rdata = 32'h281B86C4 and flags unchanged.
- Wrap and simultaneous access:
  - Write 5, read 3, then hold wr_en=rd_en=1 for 10 cycles with an incrementing pattern.
  - Required: count stays 2, order is preserved across the pointer wrap, and neither flag asserts.
- Reset mid-operation: with 3 words stored, pulse rst low; then write 32'hFEFEFEFE and read once → rdata = 32'hFEFEFEFE and empty_flag=1. No stale pre-reset data is returned.
